// File: rtl/sram_rdata_align_pkg.sv
// sram_rdata_align_pkg: width-config codes and bundle types shared by
// the SRAM read aligner and the write-side lane mux.
package sram_rdata_align_pkg;

  localparam logic [1:0] CONF_W32  = 2'b00;
  localparam logic [1:0] CONF_W16  = 2'b01;
  localparam logic [1:0] CONF_W8   = 2'b10;
  localparam logic [1:0] CONF_RSVD = 2'b11;

  typedef struct packed {
    logic [1:0] conf;
    logic [1:0] addr_lo;
    logic       sgn;
  } rd_meta_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_ent_t;

endpackage

// File: rtl/sram_rdata_align_if.sv
// sram_rdata_align_if: request, SRAM and response signals of the aligner.
// slave = aligner side, master = requester/SRAM/consumer side.
interface sram_rdata_align_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_conf;
  logic [1:0]  req_addr_lo;
  logic        req_signed;
  logic        sram_re;
  logic [31:0] sram_dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_conf, req_addr_lo, req_signed,
    input  sram_dout, rsp_ready,
    output req_ready, sram_re, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_conf, req_addr_lo, req_signed,
    output sram_dout, rsp_ready,
    input  req_ready, sram_re, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/sram_rdata_fifo.sv
// sram_rdata_fifo: DEPTH x W synchronous response FIFO.
// push_i/wdata_i write, pop_i reads head; valid_o/rdata_o = head entry.
module sram_rdata_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    unique case (1'b1)
      (push_i & ~pop_i): cnt_d = cnt_q + 1'b1;
      (pop_i & ~push_i): cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  // Head is forced to zero when empty so idle outputs are clean.
  assign valid_o = (cnt_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;

endmodule

// File: rtl/sram_rdata_align.sv
// sram_rdata_align: SRAM read-side lane aligner with credit-protected FIFO.
// Ports: clk, rst (async, active-high), bus (request/SRAM/response).
module sram_rdata_align
  import sram_rdata_align_pkg::*;
#(
  parameter int SRAM_LAT = 1,
  parameter int DEPTH    = 2
) (
  input logic               clk,
  input logic               rst,
  sram_rdata_align_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       credits_q, credits_d;
  logic                req_ready;
  logic                accept;
  logic                pop;
  logic [SRAM_LAT-1:0] vld_q;
  rd_meta_t            meta_q [SRAM_LAT];
  rd_meta_t            meta_in;
  rsp_ent_t            cap;
  rsp_ent_t            head;
  logic                head_vld;

  function automatic rsp_ent_t lane_extract(
    input rd_meta_t    m,
    input logic [31:0] d
  );
    rsp_ent_t    r;
    logic [15:0] h;
    logic [7:0]  b;
    h      = m.addr_lo[1] ? d[31:16] : d[15:0];
    b      = d[{m.addr_lo, 3'b000} +: 8];
    r.err  = (m.conf == CONF_RSVD);
    r.data = d;
    unique case (1'b1)
      (m.conf == CONF_W16):
        r.data = {{16{m.sgn & h[15]}}, h};
      (m.conf == CONF_W8):
        r.data = {{24{m.sgn & b[7]}}, b};
      default: ;
    endcase
    return r;
  endfunction

  // Credits only count from the registered counter, so
  // req_ready never depends combinationally on rsp_ready.
  assign req_ready = (credits_q != '0);
  assign accept    = bus.req_valid & req_ready;
  assign pop       = head_vld & bus.rsp_ready;

  assign meta_in.conf    = bus.req_conf;
  assign meta_in.addr_lo = bus.req_addr_lo;
  assign meta_in.sgn     = bus.req_signed;

  always_comb begin
    credits_d = credits_q;
    unique case (1'b1)
      (accept & ~pop): credits_d = credits_q - 1'b1;
      (pop & ~accept): credits_d = credits_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CW'(DEPTH);
    end else begin
      credits_q <= credits_d;
    end
  end

  // Metadata rides alongside the SRAM access latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < SRAM_LAT; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= accept;
      meta_q[0] <= meta_in;
      for (int i = 1; i < SRAM_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        meta_q[i] <= meta_q[i-1];
      end
    end
  end

  assign cap = lane_extract(meta_q[SRAM_LAT-1], bus.sram_dout);

  sram_rdata_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rsp_ent_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_q[SRAM_LAT-1]),
    .wdata_i (cap),
    .pop_i   (pop),
    .valid_o (head_vld),
    .rdata_o (head)
  );

  assign bus.req_ready = req_ready;
  assign bus.sram_re   = accept;
  assign bus.rsp_valid = head_vld;
  assign bus.rsp_data  = head.data;
  assign bus.rsp_err   = head.err;

endmodule
